// File: rtl/pkmc_sdram_defines.sv
// SDRAM command/state encodings and default timing values shared by the PKMC
// controller and its init/refresh sequencer.
package pkmc_sdram_defines;

   // {cs_n, ras_n, cas_n, we_n}
   typedef logic [3:0] sdram_cmd_t;

   localparam sdram_cmd_t CMD_INHIBIT   = 4'b1111;
   localparam sdram_cmd_t CMD_NOP       = 4'b0111;
   localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
   localparam sdram_cmd_t CMD_AREF      = 4'b0001;
   localparam sdram_cmd_t CMD_LMR       = 4'b0000;

   typedef enum logic [3:0] {
      ST_WAIT_PWR,
      ST_PRE,
      ST_WAIT_RP,
      ST_AREF,
      ST_WAIT_RFC,
      ST_LMR,
      ST_WAIT_MRD,
      ST_READY,
      ST_REF_REQ,
      ST_REF_CMD,
      ST_REF_WAIT
   } init_state_t;

   localparam int          DEF_T_RP         = 2;
   localparam int          DEF_T_RFC        = 7;
   localparam int          DEF_T_MRD        = 2;
   localparam int          DEF_INIT_REFS    = 8;
   localparam int          DEF_REF_INTERVAL = 390;
   localparam logic [12:0] DEF_MODE_REG     = 13'h0022;

   // A10 high selects all banks for PRECHARGE
   localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

endpackage

// File: rtl/pkmc_sdram_initseq_if.sv
// Command-pin and refresh-handshake bundle between the init/refresh sequencer
// (master) and the main controller / pin mux (slave).
interface pkmc_sdram_initseq_if;
   import pkmc_sdram_defines::*;

   logic        init_done;
   logic        ref_gnt;
   sdram_cmd_t  cmd;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic        cke;
   logic        owns_bus;
   logic        ready;
   logic        ref_req;
   logic        ref_overflow;

   modport master (
      input  init_done, ref_gnt,
      output cmd, addr, ba, cke, owns_bus, ready, ref_req, ref_overflow
   );

   modport slave (
      output init_done, ref_gnt,
      input  cmd, addr, ba, cke, owns_bus, ready, ref_req, ref_overflow
   );

endinterface

// File: rtl/pkmc_sdram_waitcnt.sv
// Loadable 8-bit down-counter that stops at zero; done is high while the count
// is zero. One instance times every post-command wait of the sequencer.
module pkmc_sdram_waitcnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [7:0] i_val,
   output logic       o_done
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != 8'd0) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/pkmc_sdram_initseq.sv
// SDRAM power-up sequencer (PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE) with all
// outputs registered. Periodic refresh scheduling exists only with PKMC_SDRAM_AUTOREFRESH_EN.
module pkmc_sdram_initseq
   import pkmc_sdram_defines::*;
#(
   parameter int          T_RP         = DEF_T_RP,
   parameter int          T_RFC        = DEF_T_RFC,
   parameter int          T_MRD        = DEF_T_MRD,
   parameter int          INIT_REFS    = DEF_INIT_REFS,
   parameter int          REF_INTERVAL = DEF_REF_INTERVAL,
   parameter logic [12:0] MODE_REG     = DEF_MODE_REG
) (
   input  logic                  clk,
   input  logic                  rst,
   pkmc_sdram_initseq_if.master  bus
);

   init_state_t r_state;
   sdram_cmd_t  r_cmd;
   logic [12:0] r_addr;
   logic [1:0]  r_ba;
   logic        r_cke;
   logic        r_owns;
   logic        r_ready;
   logic        r_ref_req;
   logic [3:0]  r_refs;

   logic        w_ld;
   logic [7:0]  w_ld_val;
   logic        w_t_one;
   logic        w_wc_done;
   logic        w_expired;

   // Counter is loaded during the command cycle with T-2 so it reads zero in the
   // last wait cycle; T=1 has no wait cycle at all.
   always_comb begin
      w_ld     = 1'b0;
      w_ld_val = 8'd0;
      w_t_one  = 1'b0;
      case (r_state)
         ST_PRE: begin
            w_ld     = 1'b1;
            w_ld_val = 8'(T_RP - 2);
            w_t_one  = (T_RP == 1);
         end
         ST_AREF, ST_REF_CMD: begin
            w_ld     = 1'b1;
            w_ld_val = 8'(T_RFC - 2);
            w_t_one  = (T_RFC == 1);
         end
         ST_LMR: begin
            w_ld     = 1'b1;
            w_ld_val = 8'(T_MRD - 2);
            w_t_one  = (T_MRD == 1);
         end
         default: ;
      endcase
   end

   assign w_expired = w_ld ? w_t_one : w_wc_done;

   pkmc_sdram_waitcnt u_waitcnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_ld),
      .i_val  (w_ld_val),
      .o_done (w_wc_done)
   );

`ifdef PKMC_SDRAM_AUTOREFRESH_EN
   localparam int IVL_W = $clog2(REF_INTERVAL);

   logic [IVL_W-1:0] r_ivl;
   logic [2:0]       r_pend;
   logic             r_ovf;
   logic             w_tick;
   logic             w_ref_dec;

   assign w_tick    = r_ready && (r_ivl == IVL_W'(REF_INTERVAL - 1));
   assign w_ref_dec = (r_state == ST_REF_CMD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ivl  <= '0;
         r_pend <= 3'd0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_tick) begin
            r_ivl <= '0;
         end else if (r_ready) begin
            r_ivl <= r_ivl + IVL_W'(1);
         end
         // A tick and an issued refresh in the same cycle cancel out.
         if (w_tick && !w_ref_dec) begin
            if (r_pend == 3'd7) begin
               r_ovf <= 1'b1;
            end else begin
               r_pend <= r_pend + 3'd1;
            end
         end else if (!w_tick && w_ref_dec) begin
            r_pend <= r_pend - 3'd1;
         end
      end
   end

   assign bus.ref_overflow = r_ovf;
`else
   logic w_unused_cfg;
   assign w_unused_cfg     = bus.ref_gnt | (REF_INTERVAL < 16);
   assign bus.ref_overflow = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_WAIT_PWR;
         r_cmd     <= CMD_INHIBIT;
         r_addr    <= 13'd0;
         r_ba      <= 2'd0;
         r_cke     <= 1'b0;
         r_owns    <= 1'b1;
         r_ready   <= 1'b0;
         r_ref_req <= 1'b0;
         r_refs    <= 4'd0;
      end else begin
         r_cmd     <= CMD_NOP;
         r_addr    <= 13'd0;
         r_ba      <= 2'd0;
         r_ref_req <= 1'b0;
         case (r_state)
            ST_WAIT_PWR: begin
               r_cmd <= CMD_INHIBIT;
               if (bus.init_done) begin
                  r_state <= ST_PRE;
                  r_cke   <= 1'b1;
                  r_cmd   <= CMD_PRECHARGE;
                  r_addr  <= ADDR_PRE_ALL;
                  r_refs  <= 4'(INIT_REFS);
               end
            end
            ST_PRE, ST_WAIT_RP: begin
               if (w_expired) begin
                  r_state <= ST_AREF;
                  r_cmd   <= CMD_AREF;
                  r_refs  <= r_refs - 4'd1;
               end else begin
                  r_state <= ST_WAIT_RP;
               end
            end
            ST_AREF, ST_WAIT_RFC: begin
               if (w_expired) begin
                  if (r_refs != 4'd0) begin
                     r_state <= ST_AREF;
                     r_cmd   <= CMD_AREF;
                     r_refs  <= r_refs - 4'd1;
                  end else begin
                     r_state <= ST_LMR;
                     r_cmd   <= CMD_LMR;
                     r_addr  <= MODE_REG;
                  end
               end else begin
                  r_state <= ST_WAIT_RFC;
               end
            end
            ST_LMR, ST_WAIT_MRD: begin
               if (w_expired) begin
                  r_state <= ST_READY;
                  r_ready <= 1'b1;
                  r_owns  <= 1'b0;
               end else begin
                  r_state <= ST_WAIT_MRD;
               end
            end
`ifdef PKMC_SDRAM_AUTOREFRESH_EN
            ST_READY: begin
               if (r_pend != 3'd0) begin
                  r_state   <= ST_REF_REQ;
                  r_ref_req <= 1'b1;
               end
            end
            ST_REF_REQ: begin
               r_ref_req <= 1'b1;
               if (bus.ref_gnt) begin
                  r_state   <= ST_REF_CMD;
                  r_cmd     <= CMD_AREF;
                  r_owns    <= 1'b1;
                  r_ref_req <= 1'b0;
               end
            end
            ST_REF_CMD, ST_REF_WAIT: begin
               if (w_expired) begin
                  r_state <= ST_READY;
                  r_owns  <= 1'b0;
               end else begin
                  r_state <= ST_REF_WAIT;
               end
            end
`else
            ST_READY: ;
`endif
            default: r_state <= ST_WAIT_PWR;
         endcase
      end
   end

   assign bus.cmd      = r_cmd;
   assign bus.addr     = r_addr;
   assign bus.ba       = r_ba;
   assign bus.cke      = r_cke;
   assign bus.owns_bus = r_owns;
   assign bus.ready    = r_ready;
   assign bus.ref_req  = r_ref_req;

endmodule

// File: tb/tb_pkmc_sdram_initseq.sv
// Self-checking bench for pkmc_sdram_initseq: init command schedule, reset
// behaviour and (when PKMC_SDRAM_AUTOREFRESH_EN is defined) refresh scheduling.
module tb_pkmc_sdram_initseq;

   localparam int          T_RP = 2, T_RFC = 7, T_MRD = 2, INIT_REFS = 8, REF_INTERVAL = 390;
   localparam logic [12:0] MODE_REG = 13'h0022;
   localparam logic [3:0]  C_INH = 4'b1111, C_NOP = 4'b0111, C_PRE = 4'b0010, C_AREF = 4'b0001, C_LMR = 4'b0000;
   // First AREF, LOAD MODE and ready-rise cycles, counting PRECHARGE as cycle 1
   localparam int          A0  = 1 + T_RP;
   localparam int          LMR = A0 + INIT_REFS * T_RFC;
   localparam int          R   = LMR + T_MRD;
   localparam logic [24:0] RST_VEC = {C_INH, 13'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   t = 0;

   pkmc_sdram_initseq_if bus ();

   pkmc_sdram_initseq #(
      .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .INIT_REFS(INIT_REFS),
      .REF_INTERVAL(REF_INTERVAL), .MODE_REG(MODE_REG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      t++;
      @(negedge clk);
   endtask

   function automatic logic [3:0] init_cmd_at(int c);
      if (c == 1) return C_PRE;
      if (c >= A0 && c < LMR && ((c - A0) % T_RFC) == 0) return C_AREF;
      if (c == LMR) return C_LMR;
      return C_NOP;
   endfunction

   function automatic bit tick_at(int c);
      return (c >= R) && (((c - R) % REF_INTERVAL) == REF_INTERVAL - 1);
   endfunction

   function automatic logic [24:0] out_vec();
      return {bus.cmd, bus.addr, bus.ba, bus.cke, bus.owns_bus, bus.ready, bus.ref_req, bus.ref_overflow};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.init_done = 1'b0;
      bus.ref_gnt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_vec() !== RST_VEC) begin n_err++; $display("FAIL reset_values: got %h want %h", out_vec(), RST_VEC); end
      rst = 1'b0;
      step();
      n_cmp++;
      if (out_vec() !== RST_VEC) begin n_err++; $display("FAIL reset_release_idle: got %h want %h", out_vec(), RST_VEC); end
   endtask

   task automatic test_wait_pwr();
      int n;
      n = 50 + $urandom_range(0, 20);
      repeat (n) begin
         bus.ref_gnt = 1'($urandom_range(0, 1));
         step();
         n_cmp++;
         if ({bus.cmd, bus.cke, bus.ready, bus.owns_bus} !== {C_INH, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL wait_pwr t=%0d: got cmd=%b cke=%b ready=%b owns=%b want cmd=1111 cke=0 ready=0 owns=1",
                     t, bus.cmd, bus.cke, bus.ready, bus.owns_bus);
         end
      end
   endtask

   task automatic test_init_seq();
      logic [3:0] ec;
      bus.init_done = 1'b1;
      t = 0;
      while (t < R + 8) begin
         step();
         bus.init_done = 1'($urandom_range(0, 1));
         bus.ref_gnt = 1'($urandom_range(0, 1));
         ec = init_cmd_at(t);
         n_cmp++;
         if (bus.cmd !== ec) begin n_err++; $display("FAIL init_cmd t=%0d: got %b want %b", t, bus.cmd, ec); end
         n_cmp++;
         if ({bus.cke, bus.ready, bus.owns_bus} !== {1'b1, (t >= R), (t < R)}) begin
            n_err++;
            $display("FAIL init_flags t=%0d: got cke/ready/owns=%b%b%b want %b%b%b",
                     t, bus.cke, bus.ready, bus.owns_bus, 1'b1, (t >= R), (t < R));
         end
         if (ec == C_PRE) begin
            n_cmp++;
            if ({bus.addr[10], bus.ba} !== 3'b100) begin n_err++; $display("FAIL pre_addr: got a10=%b ba=%b want a10=1 ba=0", bus.addr[10], bus.ba); end
         end
         if (ec == C_LMR) begin
            n_cmp++;
            if ({bus.addr, bus.ba} !== {MODE_REG, 2'b00}) begin n_err++; $display("FAIL lmr_addr: got %h/%0d want %h/0", bus.addr, bus.ba, MODE_REG); end
         end
      end
   endtask

`ifdef PKMC_SDRAM_AUTOREFRESH_EN
   task automatic test_periodic();
      int off, n_ref;
      bit e_aref, e_owns, e_req;
      n_ref = 0;
      bus.ref_gnt = 1'b1;
      while (t < R + 4 * REF_INTERVAL + 20) begin
         step();
         off = t - (R + REF_INTERVAL + 2);
         e_aref = (off >= 0) && ((off % REF_INTERVAL) == 0);
         e_owns = (off >= 0) && ((off % REF_INTERVAL) < T_RFC);
         e_req  = (off >= -1) && (((off + 1) % REF_INTERVAL) == 0);
         if (bus.cmd === C_AREF) n_ref++;
         n_cmp++;
         if ({bus.cmd, bus.owns_bus, bus.ref_req} !== {(e_aref ? C_AREF : C_NOP), e_owns, e_req}) begin
            n_err++;
            $display("FAIL periodic t=%0d: got cmd=%b owns=%b req=%b want cmd=%b owns=%b req=%b",
                     t, bus.cmd, bus.owns_bus, bus.ref_req, (e_aref ? C_AREF : C_NOP), e_owns, e_req);
         end
      end
      n_cmp++;
      if (n_ref != 4 || bus.ref_overflow !== 1'b0) begin n_err++; $display("FAIL periodic_count: got %0d refs ovf=%b want 4 refs ovf=0", n_ref, bus.ref_overflow); end
   endtask

   task automatic test_overflow();
      int pend, prev_pend, n_exp, n_ref, last;
      bit ovf;
      pend = 0; prev_pend = 0; ovf = 0;
      bus.ref_gnt = 1'b0;
      repeat (8 * REF_INTERVAL + 10 + $urandom_range(0, 50)) begin
         step();
         n_cmp++;
         if ({bus.cmd, bus.ref_req, bus.ref_overflow} !== {C_NOP, (prev_pend > 0), ovf}) begin
            n_err++;
            $display("FAIL overflow_hold t=%0d: got cmd=%b req=%b ovf=%b want cmd=%b req=%b ovf=%b",
                     t, bus.cmd, bus.ref_req, bus.ref_overflow, C_NOP, (prev_pend > 0), ovf);
         end
         prev_pend = pend;
         if (tick_at(t)) begin
            if (pend == 7) ovf = 1'b1;
            else pend++;
         end
      end
      n_cmp++;
      if (bus.ref_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b want 1", bus.ref_overflow); end
      n_exp = pend; n_ref = 0; last = -1000;
      bus.ref_gnt = 1'b1;
      repeat (100) begin
         step();
         if (bus.cmd === C_AREF) begin
            if (n_ref > 0) begin
               n_cmp++;
               if (t - last < T_RFC) begin n_err++; $display("FAIL drain_spacing t=%0d: got gap %0d want >= %0d", t, t - last, T_RFC); end
            end
            n_ref++;
            last = t;
         end
         if (tick_at(t)) n_exp++;
      end
      n_cmp++;
      if (n_ref != n_exp) begin n_err++; $display("FAIL drain_count: got %0d refs want %0d", n_ref, n_exp); end
      n_cmp++;
      if ({bus.ref_req, bus.owns_bus, bus.ref_overflow} !== 3'b001) begin
         n_err++;
         $display("FAIL drain_end: got req=%b owns=%b ovf=%b want req=0 owns=0 ovf=1", bus.ref_req, bus.owns_bus, bus.ref_overflow);
      end
   endtask

   task automatic test_coincident();
      int t1, t2, n;
      bus.ref_gnt = 1'b0;
      t1 = R + ((t - R) / REF_INTERVAL) * REF_INTERVAL + REF_INTERVAL - 1;
      if (t1 <= t) t1 += REF_INTERVAL;
      t2 = t1 + REF_INTERVAL;
      while (t < t2 - 1) step();
      n_cmp++;
      if (bus.ref_req !== 1'b1) begin n_err++; $display("FAIL coinc_waiting: got req=%b want 1", bus.ref_req); end
      bus.ref_gnt = 1'b1;
      step();
      bus.ref_gnt = 1'b0;
      n_cmp++;
      if (bus.cmd !== C_AREF || !tick_at(t)) begin n_err++; $display("FAIL coinc_aref t=%0d: got cmd=%b want %b on tick cycle", t, bus.cmd, C_AREF); end
      repeat (T_RFC + 2) step();
      n_cmp++;
      if ({bus.ref_req, bus.owns_bus} !== 2'b10) begin n_err++; $display("FAIL coinc_pend_kept: got req=%b owns=%b want req=1 owns=0", bus.ref_req, bus.owns_bus); end
      bus.ref_gnt = 1'b1;
      n = 0;
      repeat (40) begin
         step();
         if (bus.cmd === C_AREF) n++;
      end
      n_cmp++;
      if (n != 1 || bus.ref_req !== 1'b0) begin n_err++; $display("FAIL coinc_drain: got %0d refs req=%b want 1 refs req=0", n, bus.ref_req); end
   endtask
`else
   task automatic test_no_refresh();
      repeat (REF_INTERVAL * 3) begin
         bus.ref_gnt = 1'($urandom_range(0, 1));
         step();
         n_cmp++;
         if ({bus.cmd, bus.owns_bus, bus.ready, bus.ref_req, bus.ref_overflow} !== {C_NOP, 4'b0100}) begin
            n_err++;
            $display("FAIL no_refresh t=%0d: got cmd=%b owns=%b ready=%b req=%b ovf=%b want cmd=0111 owns=0 ready=1 req=0 ovf=0",
                     t, bus.cmd, bus.owns_bus, bus.ready, bus.ref_req, bus.ref_overflow);
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      int stop;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_vec() !== RST_VEC) begin n_err++; $display("FAIL reset_async_ready: got %h want %h", out_vec(), RST_VEC); end
      bus.init_done = 1'b0;
      bus.ref_gnt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.init_done = 1'b1;
      t = 0;
      stop = A0 + 1 + $urandom_range(0, T_RFC - 2);
      while (t < stop) step();
      n_cmp++;
      if (bus.cmd !== C_NOP || bus.cke !== 1'b1) begin n_err++; $display("FAIL mid_wait_rfc t=%0d: got cmd=%b cke=%b want cmd=0111 cke=1", t, bus.cmd, bus.cke); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_vec() !== RST_VEC) begin n_err++; $display("FAIL reset_async_rfc: got %h want %h", out_vec(), RST_VEC); end
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      while (t < A0 + T_RFC + 1) begin
         step();
         n_cmp++;
         if (bus.cmd !== init_cmd_at(t) || bus.cke !== 1'b1) begin
            n_err++;
            $display("FAIL restart t=%0d: got cmd=%b cke=%b want cmd=%b cke=1", t, bus.cmd, bus.cke, init_cmd_at(t));
         end
      end
   endtask

   initial begin
      test_reset();
      test_wait_pwr();
      test_init_seq();
`ifdef PKMC_SDRAM_AUTOREFRESH_EN
      test_periodic();
      test_overflow();
      test_coincident();
`else
      test_no_refresh();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule
